// File: rtl/seg_scan_mux.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// Double-buffers the loaded value so a frame never tears, and flags leading zeros for blanking.
module seg_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  output logic [3:0]              digit_hex,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    digit_blank,
  output logic                    frame_done
);

  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int FRAME_W = 4 * NUM_DIGITS;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]      div_cnt;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      nidx;
  logic [FRAME_W-1:0]    disp;
  logic [FRAME_W-1:0]    pending;
  logic [FRAME_W-1:0]    frame_next;
  logic                  pend_v;
  logic                  scan_tick;
  logic                  wrap_tick;
  logic                  run_zero;
  logic [NUM_DIGITS-1:0] lz_vec;
  logic [NUM_DIGITS-1:0] sel_next;
  logic [3:0]            hex_next;
  logic                  blank_next;

  // frame_next is what disp holds after this edge, so digit 0 of a new frame shows fresh data
  always_comb begin
    scan_tick  = en && (div_cnt == DIV_LAST);
    wrap_tick  = scan_tick && (idx == IDX_LAST);
    nidx       = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    frame_next = disp;
    if (wrap_tick) begin
      if (load)
        frame_next = value;
      else if (pend_v)
        frame_next = pending;
    end

    // lz_vec[i]: nibbles i..top are all zero; bit 0 stays clear so digit 0 always shows
    lz_vec   = '0;
    run_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run_zero  = run_zero & (frame_next[4*i +: 4] == 4'h0);
      lz_vec[i] = run_zero;
    end

    sel_next       = '1;
    sel_next[nidx] = 1'b0;
    hex_next       = frame_next[4*nidx +: 4];
    blank_next     = blank_lz & lz_vec[nidx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      idx         <= IDX_LAST;
      disp        <= '0;
      pending     <= '0;
      pend_v      <= 1'b0;
      digit_sel   <= '1;
      digit_hex   <= 4'h0;
      digit_blank <= 1'b1;
      frame_done  <= 1'b0;
    end else if (!en) begin
      div_cnt     <= '0;
      idx         <= IDX_LAST;
      digit_sel   <= '1;
      digit_blank <= 1'b1;
      frame_done  <= 1'b0;
      if (load) begin
        pending <= value;
        pend_v  <= 1'b1;
      end
    end else begin
      div_cnt    <= scan_tick ? '0 : div_cnt + 1'b1;
      frame_done <= wrap_tick;
      if (scan_tick) begin
        idx         <= nidx;
        digit_sel   <= sel_next;
        digit_hex   <= hex_next;
        digit_blank <= blank_next;
      end
      // a load landing on the wrap tick goes straight to disp and drops any pending frame
      if (wrap_tick) begin
        disp   <= frame_next;
        pend_v <= 1'b0;
      end else if (load) begin
        pending <= value;
        pend_v  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: a cycle-level reference model queues expected outputs,
// and a monitor on the falling edge pops and compares them against the DUT.
module tb_seg_scan_mux;

  localparam int N   = 4;
  localparam int DIV = 4;

  typedef struct packed {
    logic [3:0]   hex;
    logic [N-1:0] sel;
    logic         blank;
    logic         fd;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           en;
  logic           load;
  logic [4*N-1:0] value;
  logic           blank_lz;
  logic [3:0]     digit_hex;
  logic [N-1:0]   digit_sel;
  logic           digit_blank;
  logic           frame_done;

  exp_t exp_q[$];
  int   checks_total;
  int   checks_passed;

  seg_scan_mux #(.NUM_DIGITS(N), .CLK_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .value      (value),
    .blank_lz   (blank_lz),
    .digit_hex  (digit_hex),
    .digit_sel  (digit_sel),
    .digit_blank(digit_blank),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: counts enabled cycles k; every DIV-th cycle is tick number m, showing digit m mod N
  int unsigned    k;
  int unsigned    m;
  int             d;
  logic [4*N-1:0] frame;
  logic [4*N-1:0] pend;
  bit             pv;
  exp_t           cur;

  always @(posedge clk) begin
    if (rst) begin
      k     = 0;
      m     = 0;
      frame = '0;
      pend  = '0;
      pv    = 1'b0;
      cur   = '{hex: 4'h0, sel: '1, blank: 1'b1, fd: 1'b0};
    end else if (!en) begin
      k = 0;
      m = 0;
      if (load) begin
        pend = value;
        pv   = 1'b1;
      end
      cur.sel   = '1;
      cur.blank = 1'b1;
      cur.fd    = 1'b0;
    end else begin
      cur.fd = 1'b0;
      if ((k % DIV) == DIV - 1) begin
        d = int'(m % N);
        m++;
        if (d == 0) begin
          if (load) frame = value;
          else if (pv) frame = pend;
          pv     = 1'b0;
          cur.fd = 1'b1;
        end else if (load) begin
          pend = value;
          pv   = 1'b1;
        end
        cur.hex   = 4'((frame >> (4*d)) & 16'hF);
        cur.sel   = ~(N'(1) << d);
        cur.blank = blank_lz && (d > 0) && ((frame >> (4*d)) == 0);
      end else if (load) begin
        pend = value;
        pv   = 1'b1;
      end
      k++;
    end
    exp_q.push_back(cur);
  end

  task automatic checkField(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks_total++;
    if (actual === expected)
      checks_passed++;
    else
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("digit_hex",   8'(digit_hex),   8'(e.hex));
    checkField("digit_sel",   8'(digit_sel),   8'(e.sel));
    checkField("digit_blank", 8'(digit_blank), 8'(e.blank));
    checkField("frame_done",  8'(frame_done),  8'(e.fd));
  endtask

  // Monitor: outputs only move on rising edges, so the falling edge is a stable sample point
  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  task automatic applyStimulus(input logic r, input logic e, input logic l,
                               input logic [4*N-1:0] v, input logic b, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      rst      = r;
      en       = e;
      load     = (c == 0) ? l : 1'b0;
      value    = v;
      blank_lz = b;
    end
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst      = 1'b1;
    en       = 1'b1;
    load     = 1'b0;
    value    = '0;
    blank_lz = 1'b0;

    applyStimulus(1, 1, 0, 16'h0000, 0, 3);
    applyStimulus(0, 1, 0, 16'h0000, 0, 20);
    applyStimulus(0, 1, 1, 16'h1A3F, 0, 40);
    applyStimulus(0, 1, 1, 16'h0050, 1, 40);
    applyStimulus(0, 1, 1, 16'h0000, 1, 40);
    applyStimulus(0, 1, 1, 16'h1A3F, 0, 36);
    applyStimulus(0, 1, 1, 16'h1234, 0, 30);
    applyStimulus(0, 1, 1, 16'h1111, 0, 3);
    applyStimulus(0, 1, 1, 16'h2222, 0, 40);
    applyStimulus(0, 0, 0, 16'h2222, 0, 5);
    applyStimulus(0, 1, 0, 16'h2222, 0, 30);
    applyStimulus(0, 1, 1, 16'h5678, 1, 2);
    applyStimulus(1, 1, 0, 16'h5678, 1, 1);
    applyStimulus(0, 1, 0, 16'h0000, 1, 40);

    // Randomized phase: frequent loads land on wrap ticks, with sparse disables and resets
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      applyStimulus(($urandom_range(0, 399) == 0),
                    ($urandom_range(0, 59) != 0),
                    ($urandom_range(0, 5) == 0),
                    (($urandom_range(0, 2) == 0) ? 16'(16'h00FF & $urandom) : 16'($urandom)),
                    blank_lz, 1);
    end

    applyStimulus(0, 1, 0, 16'h0000, blank_lz, 4);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
